// File: rtl/double_comb_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : double_comb_decim_pkg
// Purpose  : Shared constants, types and the output saturation helper for
//            the CIC comb/decimation blocks.
// Revision : 1.0 - initial release
// ============================================================================
package double_comb_decim_pkg;

  // Smallest decimation factor the window counter supports.
  localparam int c_min_period = 2;

  // Number of samples needed to fill the two comb delay elements.
  typedef logic [1:0] prime_cnt_t;
  localparam prime_cnt_t c_prime_full = 2'd2;

  localparam int c_sat_w = 64;
  localparam logic signed [c_sat_w-1:0] c_sat_max = {1'b0, {(c_sat_w-1){1'b1}}};

  // Clamp a sign-extended value to the signed range of a dwo-bit word.
  function automatic logic signed [c_sat_w-1:0] sat_dwo(
    input logic signed [c_sat_w-1:0] x,
    input int                        dwo
  );
    logic signed [c_sat_w-1:0] hi;
    logic signed [c_sat_w-1:0] lo;
    hi = c_sat_max >>> (c_sat_w - dwo);
    lo = ~hi;
    if (x > hi) begin
      sat_dwo = hi;
    end else if (x < lo) begin
      sat_dwo = lo;
    end else begin
      sat_dwo = x;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/double_comb_decim_comb_diff.sv
`default_nettype none
// ============================================================================
// Module   : comb_diff
// Purpose  : One first-difference comb stage, differential delay 1, modular.
// Revision : 1.0 - initial release
// ============================================================================
module comb_diff #(
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);

  logic [DW-1:0] r_x_z;
  logic [DW-1:0] r_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_z <= '0;
      r_y   <= '0;
    end else if (clr) begin
      r_x_z <= '0;
      r_y   <= '0;
    end else if (en) begin
      // Wrap-around is intended: the difference is exact modulo 2^DW.
      r_y   <= x - r_x_z;
      r_x_z <= x;
    end
  end

  assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/double_comb_decim.sv
`default_nettype none
// ============================================================================
// Module   : double_comb_decim
// Purpose  : Decimating double-comb section of a two-stage CIC filter with
//            runtime decimation factor, scaling and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module double_comb_decim
  import double_comb_decim_pkg::*;
#(
  parameter int DWI   = 28,
  parameter int DWO   = 20,
  parameter int PW    = 12,
  parameter int SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic signed [DWI-1:0] in,
  input  logic        [PW-1:0]  period,
  input  logic                  clear,
  output logic signed [DWO-1:0] out,
  output logic                  out_valid,
  output logic                  stb_sample
);

  logic [PW-1:0]  r_cnt;
  logic [PW-1:0]  r_ract;
  prime_cnt_t     r_prime;
  logic           r_stb_d1;
  logic           r_stb_d2;
  logic           r_vld_d1;
  logic           r_vld_d2;
  logic           r_out_valid;
  logic signed [DWO-1:0] r_out;

  logic [PW-1:0]  w_period_clamp;
  logic           w_wrap;
  logic           w_primed;
  logic [DWI-1:0] w_c1;
  logic [DWI-1:0] w_c2;
  logic signed [DWI-1:0]     w_shifted;
  logic signed [c_sat_w-1:0] w_wide;

  assign w_period_clamp = (period < PW'(c_min_period)) ? PW'(c_min_period) : period;
  assign w_wrap         = (r_cnt == r_ract - PW'(1));
  assign w_primed       = (r_prime == c_prime_full);
  // clear wins over a coincident window end: that sample is never taken.
  assign stb_sample     = w_wrap & ~clear;

  // Window counter, active period latch and priming count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_ract  <= PW'(c_min_period);
      r_prime <= '0;
    end else if (clear) begin
      r_cnt   <= '0;
      r_ract  <= w_period_clamp;
      r_prime <= '0;
    end else begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_ract <= w_period_clamp;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
      if (stb_sample && !w_primed) begin
        r_prime <= r_prime + prime_cnt_t'(1);
      end
    end
  end

  comb_diff #(.DW(DWI)) u_comb1 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .en      (stb_sample),
    .x       (in),
    .y       (w_c1)
  );

  comb_diff #(.DW(DWI)) u_comb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .en      (r_stb_d1),
    .x       (w_c1),
    .y       (w_c2)
  );

  assign w_shifted = $signed(w_c2) >>> SHIFT;
  assign w_wide    = {{(c_sat_w-DWI){w_shifted[DWI-1]}}, w_shifted};

  // Validity is decided when the sample is taken: a sample is good only if
  // both comb delays already held real data before it arrived.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stb_d1    <= 1'b0;
      r_stb_d2    <= 1'b0;
      r_vld_d1    <= 1'b0;
      r_vld_d2    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (clear) begin
      r_stb_d1    <= 1'b0;
      r_stb_d2    <= 1'b0;
      r_vld_d1    <= 1'b0;
      r_vld_d2    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_stb_d1    <= stb_sample;
      r_stb_d2    <= r_stb_d1;
      r_vld_d1    <= stb_sample & w_primed;
      r_vld_d2    <= r_vld_d1;
      r_out_valid <= r_vld_d2;
      if (r_stb_d2) begin
        r_out <= DWO'(sat_dwo(w_wide, DWO));
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_double_comb_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_double_comb_decim
// Purpose  : Self-checking bench for double_comb_decim (SHIFT=0 and SHIFT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_double_comb_decim;

  localparam longint MOD  = 64'sd268435456;
  localparam longint HALF = 64'sd134217728;
  localparam longint SMAX = 64'sd524287;
  localparam longint SMIN = -64'sd524288;
  localparam longint MASK = 64'sd268435455;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [27:0] din = '0;
  logic [11:0] period = 12'd4;
  logic clear = 1'b0;
  logic signed [19:0] out0, out8;
  logic vld0, vld8, stb0, stb8;

  double_comb_decim #(.DWI(28), .DWO(20), .PW(12), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in(din), .period(period), .clear(clear),
    .out(out0), .out_valid(vld0), .stb_sample(stb0)
  );

  double_comb_decim #(.DWI(28), .DWO(20), .PW(12), .SHIFT(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in(din), .period(period), .clear(clear),
    .out(out8), .out_valid(vld8), .stb_sample(stb8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: absolute cycle index of the next sample, the last two
  // samples taken, and a queue of expected outputs keyed by arrival cycle.
  longint cyc = 0;
  longint m_next = 0;
  longint m_s1 = 0, m_s2 = 0;
  int     m_cnt = 0;
  longint pq_t[$];
  longint pq_v0[$];
  longint pq_v8[$];
  logic   e_stb, e_valid;
  logic signed [19:0] e_out0, e_out8;

  function automatic longint model_out(longint d, int sh);
    longint v;
    v = d % MOD;
    if (v < 0) v += MOD;
    if (v >= HALF) v -= MOD;
    v = v >>> sh;
    if (v > SMAX) v = SMAX;
    else if (v < SMIN) v = SMIN;
    return v;
  endfunction

  task automatic drive(input logic [27:0] x, input logic [11:0] p, input logic clr);
    longint r, d, dummy;
    @(posedge clk);
    #1;
    cyc++;
    din = x; period = p; clear = clr;
    r = (p < 12'd2) ? 2 : longint'(p);
    e_valid = 1'b0;
    e_stb = 1'b0;
    if (pq_t.size() != 0 && pq_t[0] == cyc) begin
      e_valid = 1'b1;
      e_out0 = 20'(pq_v0.pop_front());
      e_out8 = 20'(pq_v8.pop_front());
      dummy  = pq_t.pop_front();
    end
    if (clr) begin
      pq_t.delete(); pq_v0.delete(); pq_v8.delete();
      m_cnt = 0;
      m_next = cyc + r;
    end else if (cyc == m_next) begin
      e_stb = 1'b1;
      m_next = cyc + r;
      if (m_cnt >= 2) begin
        d = longint'(x) - 2 * m_s1 + m_s2;
        pq_t.push_back(cyc + 3);
        pq_v0.push_back(model_out(d, 0));
        pq_v8.push_back(model_out(d, 8));
      end
      m_s2 = m_s1;
      m_s1 = longint'(x);
      if (m_cnt < 2) m_cnt++;
    end
    #1;
  endtask

  task automatic reset_assert();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    clear = 1'b0;
    #1;
  endtask

  task automatic reset_release();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc++;
    m_next = cyc + 1;
    m_cnt = 0;
    pq_t.delete(); pq_v0.delete(); pq_v8.delete();
    #1;
  endtask

  task automatic test_reset();
    reset_assert();
    n_checks++;
    if (out0 !== 20'sd0 || out8 !== 20'sd0) begin
      n_fail++; $display("FAIL reset_out got %0d/%0d required 0", out0, out8);
    end
    n_checks++;
    if ({vld0, vld8, stb0, stb8} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got vld=%b%b stb=%b%b required 0", vld0, vld8, stb0, stb8);
    end
    reset_release();
  endtask

  task automatic test_square();
    drive(28'd0, 12'd4, 1'b1);
    for (int n = 1; n <= 44; n++) begin
      drive(28'(n * n), 12'd4, 1'b0);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL square_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== 20'sd32 || out0 !== e_out0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL square_out cyc=%0d got %0d/%0d required 32/%0d", cyc, out0, out8, e_out8);
        end
      end
    end
  endtask

  task automatic test_ramp();
    drive(28'd0, 12'd8, 1'b1);
    for (int n = 1; n <= 60; n++) begin
      drive(28'(5 * n), 12'd8, 1'b0);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL ramp_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== 20'sd0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL ramp_out cyc=%0d got %0d/%0d required 0/%0d", cyc, out0, out8, e_out8);
        end
      end
    end
  endtask

  task automatic test_wrap();
    longint n0, v;
    n0 = 11560;
    drive(28'((n0 * n0) & MASK), 12'd16, 1'b1);
    for (int n = 1; n <= 200; n++) begin
      v = (n0 + n) * (n0 + n);
      drive(28'(v & MASK), 12'd16, 1'b0);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL wrap_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== 20'sd512 || out8 !== e_out8) begin
          n_fail++; $display("FAIL wrap_out cyc=%0d got %0d/%0d required 512/%0d", cyc, out0, out8, e_out8);
        end
      end
    end
  endtask

  task automatic test_saturation();
    longint v;
    for (int sgn = 0; sgn < 2; sgn++) begin
      drive(28'd0, 12'd2, 1'b1);
      for (int n = 1; n <= 20; n++) begin
        v = (64'sd262144 * n * n);
        if (sgn == 1) v = -v;
        drive(28'(v & MASK), 12'd2, 1'b0);
        n_checks++;
        if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
          n_fail++; $display("FAIL sat_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
        end
        if (e_valid) begin
          n_checks++;
          if (out0 !== ((sgn == 1) ? -20'sd524288 : 20'sd524287) || out8 !== e_out8) begin
            n_fail++; $display("FAIL sat_out cyc=%0d got %0d/%0d required %0d/%0d", cyc, out0, out8, e_out0, e_out8);
          end
        end
      end
    end
  endtask

  task automatic test_period_change();
    logic [11:0] p;
    drive(28'd0, 12'd4, 1'b1);
    for (int n = 1; n <= 70; n++) begin
      p = (n < 6) ? 12'd4 : (n < 40) ? 12'd6 : (n < 58) ? 12'd1 : 12'd0;
      drive(28'(3 * n * n), p, 1'b0);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL period_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== e_out0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL period_out cyc=%0d got %0d/%0d required %0d/%0d", cyc, out0, out8, e_out0, e_out8);
        end
      end
    end
  endtask

  task automatic test_clear_and_reset();
    int  n;
    bit  done, clr_now;
    drive(28'd0, 12'd4, 1'b1);
    n = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      clr_now = !done && (k >= 20) && (m_next == cyc + 1);
      if (clr_now) begin n = 0; done = 1; end else n++;
      drive(28'(n * n), 12'd4, clr_now);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid} || (clr_now && stb0 !== 1'b0)) begin
        n_fail++; $display("FAIL clear_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== e_out0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL clear_out cyc=%0d got %0d/%0d required %0d/%0d", cyc, out0, out8, e_out0, e_out8);
        end
      end
      if (done && k > 40 && e_stb) break;
    end
    // Reset arrives in the cycle right after a sample, with results in flight.
    reset_assert();
    n_checks++;
    if (out0 !== 20'sd0 || out8 !== 20'sd0 || {vld0, vld8, stb0, stb8} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset got out=%0d/%0d vld=%b%b stb=%b%b required 0", out0, out8, vld0, vld8, stb0, stb8);
    end
    reset_release();
    for (int k = 1; k <= 30; k++) begin
      drive(28'(7 * k * k), 12'd4, 1'b0);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL postreset_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== e_out0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL postreset_out cyc=%0d got %0d/%0d required %0d/%0d", cyc, out0, out8, e_out0, e_out8);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] p;
    logic        c;
    p = 12'd3;
    drive(28'd0, p, 1'b1);
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) == 0) p = 12'($urandom_range(0, 6));
      c = ($urandom_range(0, 39) == 0);
      drive(28'($urandom), p, c);
      n_checks++;
      if ({stb0, stb8, vld0, vld8} !== {e_stb, e_stb, e_valid, e_valid}) begin
        n_fail++; $display("FAIL random_ctl cyc=%0d got stb=%b%b vld=%b%b required stb=%b vld=%b", cyc, stb0, stb8, vld0, vld8, e_stb, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (out0 !== e_out0 || out8 !== e_out8) begin
          n_fail++; $display("FAIL random_out cyc=%0d got %0d/%0d required %0d/%0d", cyc, out0, out8, e_out0, e_out8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_ramp();
    test_wrap();
    test_saturation();
    test_period_change();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
